// File: rtl/blink_monitor.sv
// Receive-side blink monitor: synchronizes and debounces an asynchronous line,
// measures the half-period between debounced edges and flags a stuck line.
module blink_monitor #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 32,
  parameter int TIMEOUT         = 100000000
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 BLINK_IN,
  input  logic                 CLEAR,
  output logic                 LEVEL,
  output logic                 EDGE_RISE,
  output logic                 EDGE_FALL,
  output logic [CNT_WIDTH-1:0] HALF_PERIOD,
  output logic                 PERIOD_VALID,
  output logic                 STUCK
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0]        DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO  = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STUCK_ST
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [DW-1:0]          dcnt;
  logic                   level_q, rise_q, fall_q;
  logic                   edge_now;

  state_t                 state, state_d;
  logic [CNT_WIDTH-1:0]   icnt, icnt_d;
  logic [CNT_WIDTH-1:0]   hp_q, hp_d;
  logic                   pv_q, pv_d;
  logic                   stuck_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], BLINK_IN};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // edge_now marks the clock at which LEVEL toggles; FSM and edge pulses share it
  assign edge_now = (sync != level_q) && (dcnt == DMAX);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dcnt    <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= edge_now & ~level_q;
      fall_q <= edge_now & level_q;
      if (edge_now) begin
        level_q <= ~level_q;
        dcnt    <= '0;
      end else if (sync != level_q) begin
        dcnt <= dcnt + 1'b1;
      end else begin
        dcnt <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    icnt_d  = edge_now ? CNT_WIDTH'(1) : ((&icnt) ? icnt : icnt + 1'b1);
    hp_d    = hp_q;
    pv_d    = 1'b0;
    case (state)
      IDLE: begin
        if (edge_now)         state_d = MEASURE;
        else if (icnt == TMO) state_d = STUCK_ST;
      end
      MEASURE: begin
        if (edge_now) begin
          hp_d = icnt;
          pv_d = 1'b1;
        end else if (icnt == TMO) begin
          state_d = STUCK_ST;
        end
      end
      STUCK_ST: begin
        if (edge_now) state_d = MEASURE;
      end
      default: state_d = IDLE;
    endcase
    if (CLEAR) begin
      state_d = IDLE;
      icnt_d  = '0;
      hp_d    = '0;
      pv_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      icnt    <= '0;
      hp_q    <= '0;
      pv_q    <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      icnt    <= icnt_d;
      hp_q    <= hp_d;
      pv_q    <= pv_d;
      stuck_q <= (state_d == STUCK_ST);
    end
  end

  assign LEVEL        = level_q;
  assign EDGE_RISE    = rise_q;
  assign EDGE_FALL    = fall_q;
  assign HALF_PERIOD  = hp_q;
  assign PERIOD_VALID = pv_q;
  assign STUCK        = stuck_q;

endmodule
